// File: rtl/alu128_pkg.sv
// ============================================================================
// Module   : alu128_pkg
// Purpose  : Shared state encoding, ALU width, flag indices and command check
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu128_pkg;

    localparam int ALU_W  = 128;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_S = 0;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    // Arithmetic mode has 7 legal ops, logic mode has 5.
    function automatic logic is_illegal_cmd(input logic mode, input logic [2:0] opsel);
        return (mode && (opsel >= 3'b101)) || (!mode && (opsel == 3'b111));
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu128_operand_seq.sv
// ============================================================================
// Module   : alu128_operand_seq
// Purpose  : Serialises two 128-bit operands into an external ALU and streams
//            the result back; ALU128_STICKY_FLAGS_EN adds a sticky overflow bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu128_operand_seq
    import alu128_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [2:0]        in_opsel,
    input  logic              in_mode,
    output logic [ALU_W-1:0]  alu_op1,
    output logic [ALU_W-1:0]  alu_op2,
    output logic [2:0]        alu_opsel,
    output logic              alu_mode,
    input  logic [ALU_W-1:0]  alu_result,
    input  logic [3:0]        alu_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic [3:0]        out_flags,
    output logic              out_err
`ifdef ALU128_STICKY_FLAGS_EN
   ,input  logic              sticky_clr,
    output logic              sticky_o
`endif
);

    localparam int              BEATS     = ALU_W / WORD_W;
    localparam int              CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [CNT_W-1:0]  r_beat;
    logic [ALU_W-1:0]  r_res;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_beat_last;

    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_beat_last = (r_beat == LAST_BEAT);
    assign out_data    = r_res[r_beat*WORD_W +: WORD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        case (r_state)
            LOAD_A: begin
                in_ready = 1'b1;
                if (w_in_fire && w_beat_last) begin
                    w_state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (w_in_fire && w_beat_last) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_state_next = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_beat_last;
                if (out_ready && w_beat_last) begin
                    w_state_next = LOAD_A;
                end
            end
            default: begin
                w_state_next = LOAD_A;
            end
        endcase
    end

    // One counter serves both load phases and the drain; it is already zero in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (w_in_fire || w_out_fire) begin
            r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_opsel <= '0;
            alu_mode  <= 1'b0;
        end else if (w_in_fire) begin
            if (r_state == LOAD_A) begin
                alu_op1[r_beat*WORD_W +: WORD_W] <= in_data;
                if (r_beat == '0) begin
                    alu_opsel <= in_opsel;
                    alu_mode  <= in_mode;
                end
            end else begin
                alu_op2[r_beat*WORD_W +: WORD_W] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res     <= '0;
            out_flags <= '0;
            out_err   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_res     <= alu_result;
            out_flags <= alu_flags;
            out_err   <= is_illegal_cmd(alu_mode, alu_opsel);
        end
    end

`ifdef ALU128_STICKY_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_o <= 1'b0;
        end else if (sticky_clr) begin
            sticky_o <= 1'b0;
        end else if ((r_state == EXEC) && alu_flags[FLAG_O]) begin
            sticky_o <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu128_operand_seq.sv
// ============================================================================
// Module   : tb_alu128_operand_seq
// Purpose  : Directed self-checking bench with a behavioural adder as the ALU
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu128_operand_seq;

    localparam int WORD_W = 32;
    localparam int BEATS  = 128 / WORD_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic [2:0]        in_opsel = '0;
    logic              in_mode = 1'b0;
    logic [127:0]      alu_op1;
    logic [127:0]      alu_op2;
    logic [2:0]        alu_opsel;
    logic              alu_mode;
    logic [127:0]      alu_result;
    logic [3:0]        alu_flags;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic [3:0]        out_flags;
    logic              out_err;
`ifdef ALU128_STICKY_FLAGS_EN
    logic              sticky_clr = 1'b0;
    logic              sticky_o;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu128_operand_seq #(.WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_opsel   (in_opsel),
        .in_mode    (in_mode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_opsel  (alu_opsel),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_flags  (out_flags),
        .out_err    (out_err)
`ifdef ALU128_STICKY_FLAGS_EN
       ,.sticky_clr (sticky_clr),
        .sticky_o   (sticky_o)
`endif
    );

    // External ALU: plain 128-bit add, flags {c, z, o, s}
    logic [128:0] m_sum;
    always_comb begin
        m_sum      = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_result = m_sum[127:0];
        alu_flags  = {m_sum[128],
                      (m_sum[127:0] == 128'd0),
                      (alu_op1[127] == alu_op2[127]) && (m_sum[127] != alu_op1[127]),
                      m_sum[127]};
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input logic [2:0] op, input logic md);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_opsel = op;
        in_mode  = md;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_val("in_ready_timeout", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic load_txn(input logic [127:0] a, input logic [127:0] b,
                            input logic [2:0] op, input logic md);
        for (int k = 0; k < BEATS; k++) send_word(a[k*WORD_W +: WORD_W], op, md);
        for (int k = 0; k < BEATS; k++) send_word(b[k*WORD_W +: WORD_W], op, md);
    endtask

    task automatic drain_check(input string tag, input logic [127:0] exp,
                               input logic [3:0] exp_flags, input logic exp_err,
                               input int stall_k, input int stall_n,
                               input logic [127:0] exp_op1);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_valid"}, 128'(out_valid), 128'd1);
        for (int k = 0; k < BEATS; k++) begin
            check_val($sformatf("%s_data%0d", tag, k), 128'(out_data), 128'(exp[k*WORD_W +: WORD_W]));
            check_val($sformatf("%s_last%0d", tag, k), 128'(out_last), 128'(k == BEATS - 1));
            check_val($sformatf("%s_flags%0d", tag, k), 128'(out_flags), 128'(exp_flags));
            check_val($sformatf("%s_err%0d", tag, k), 128'(out_err), 128'(exp_err));
            if (k == stall_k) begin
                in_valid = 1'b1;
                in_data  = 32'hDEAD_BEEF;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_val($sformatf("%s_stall%0d", tag, s), 128'(out_data), 128'(exp[k*WORD_W +: WORD_W]));
                    check_val($sformatf("%s_stallv%0d", tag, s), 128'(out_valid), 128'd1);
                end
                in_valid = 1'b0;
                check_val({tag, "_op1_kept"}, alu_op1, exp_op1);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
        end
        check_val({tag, "_done_valid"}, 128'(out_valid), 128'd0);
        check_val({tag, "_done_ready"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 128'(in_ready), 128'd1);
        check_val("rst_out_valid", 128'(out_valid), 128'd0);
        check_val("rst_out_last", 128'(out_last), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("init_in_ready", 128'(in_ready), 128'd1);
        check_val("init_flags", 128'(out_flags), 128'd0);
        check_val("init_err", 128'(out_err), 128'd0);
        check_val("init_op1", alu_op1, 128'd0);
`ifdef ALU128_STICKY_FLAGS_EN
        check_val("init_sticky", 128'(sticky_o), 128'd0);
`endif

        // Signed overflow with carry out; also checks the two-cycle latency.
        load_txn(128'h80000000_00000000_00000000_00000005,
                 128'h80000000_00000000_00000000_00000009, 3'b000, 1'b0);
        @(negedge clk);
        check_val("lat_exec_valid", 128'(out_valid), 128'd0);
        check_val("lat_exec_ready", 128'(in_ready), 128'd0);
        drain_check("ovf", 128'h00000000_00000000_00000000_0000000E, 4'b1010, 1'b0, -1, 0, 128'd0);

        load_txn(128'd0, 128'd0, 3'b000, 1'b0);
        drain_check("zero", 128'd0, 4'b0100, 1'b0, -1, 0, 128'd0);

        // Backpressure on word 2 with in_valid asserted meanwhile.
        load_txn(128'h00000004_00000003_00000002_00000001,
                 128'h00000040_00000030_00000020_00000010, 3'b000, 1'b0);
        drain_check("bp", 128'h00000044_00000033_00000022_00000011, 4'b0000, 1'b0, 2, 5,
                    128'h00000004_00000003_00000002_00000001);

        load_txn(128'd1, 128'd2, 3'b110, 1'b1);
        check_val("ill_opsel", 128'(alu_opsel), 128'h6);
        check_val("ill_mode", 128'(alu_mode), 128'd1);
        drain_check("ill", 128'd3, 4'b0000, 1'b1, -1, 0, 128'd0);
        load_txn(128'd7, 128'd8, 3'b011, 1'b0);
        drain_check("legal", 128'd15, 4'b0000, 1'b0, -1, 0, 128'd0);

        // Reset in the middle of loading A.
        for (int k = 0; k < 3; k++) send_word(32'hAAAA_0000 + 32'(k), 3'b001, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_in_ready", 128'(in_ready), 128'd1);
        check_val("midrst_out_valid", 128'(out_valid), 128'd0);
        check_val("midrst_op1", alu_op1, 128'd0);
        check_val("midrst_opsel", 128'(alu_opsel), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_txn({4{32'h11111111}}, {4{32'h22222222}}, 3'b000, 1'b0);
        drain_check("post_rst", {4{32'h33333333}}, 4'b0000, 1'b0, -1, 0, 128'd0);

`ifdef ALU128_STICKY_FLAGS_EN
        load_txn(128'h80000000_00000000_00000000_00000000,
                 128'h80000000_00000000_00000000_00000000, 3'b000, 1'b0);
        drain_check("stk1", 128'd0, 4'b1110, 1'b0, -1, 0, 128'd0);
        check_val("sticky_set", 128'(sticky_o), 128'd1);
        load_txn(128'h80000000_00000000_00000000_00000000,
                 128'h80000000_00000000_00000000_00000000, 3'b000, 1'b0);
        drain_check("stk2", 128'd0, 4'b1110, 1'b0, -1, 0, 128'd0);
        check_val("sticky_hold", 128'(sticky_o), 128'd1);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        @(negedge clk);
        check_val("sticky_clr", 128'(sticky_o), 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu128_operand_seq.md
ALU128_OPERAND_SEQ -- requirements
Module: alu128_operand_seq

Interface
REQ-001 SHALL have parameter WORD_W, default 32: bus word width; legal values 8, 16, 32, 64; BEATS = 128/WORD_W.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: upstream word valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts a word.
REQ-006 SHALL have port in_data, input, WORD_W: operand word, least-significant word first.
REQ-007 SHALL have port in_opsel, input, 3: operation select, sampled on beat 0 of A.
REQ-008 SHALL have port in_mode, input, 1: 0 = arithmetic, 1 = logic, sampled on beat 0 of A.
REQ-009 SHALL have ports alu_op1 and alu_op2, outputs, 128 each: registered operands to the ALU.
REQ-010 SHALL have ports alu_opsel (output, 3) and alu_mode (output, 1): registered command to the ALU.
REQ-011 SHALL have port alu_result, input, 128: combinational ALU result.
REQ-012 SHALL have port alu_flags, input, 4: {c, z, o, s} from the ALU.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, WORD_W) and out_last (output, 1): result word stream.
REQ-014 SHALL have port out_flags, output, 4: captured {c, z, o, s}, stable through the whole drain.
REQ-015 SHALL have port out_err, output, 1: captured command was illegal.

Function
REQ-016 SHALL implement FSM states LOAD_A, LOAD_B, EXEC and DRAIN; reset state is LOAD_A.
REQ-017 SHALL hold in_ready = 1 in LOAD_A and LOAD_B only, and 0 in EXEC and DRAIN.
REQ-018 SHALL accept a word only on in_valid && in_ready, storing beat k into bits [k*WORD_W +: WORD_W] of A (in LOAD_A) or of B (in LOAD_B).
REQ-019 SHALL move to the next state after beat BEATS-1 is accepted in a load state: LOAD_A -> LOAD_B, LOAD_B -> EXEC.
REQ-020 SHALL drive alu_op1, alu_op2, alu_opsel and alu_mode from internal registers, changing only on accepted load beats.
REQ-021 SHALL stay in EXEC exactly one cycle, capture alu_result, alu_flags and the illegal-command indication at the end of that cycle, then enter DRAIN.
REQ-022 SHALL treat as illegal: mode 0 with opsel 111, and mode 1 with opsel 101, 110 or 111; illegal commands are still executed, with out_err = 1.
REQ-023 SHALL in DRAIN assert out_valid, present result word k (LSW first) on out_data, and advance k only on out_valid && out_ready.
REQ-024 SHALL assert out_last only with word BEATS-1; its handshake returns the FSM to LOAD_A and clears the beat counter.
REQ-025 SHALL hold out_data, out_flags and out_err stable while out_valid && !out_ready (backpressure).
REQ-026 SHALL give latency from the final B handshake to out_valid = 1 of exactly 2 cycles (one EXEC cycle plus one capture cycle).
REQ-027 SHALL ignore in_valid outside the load states; words are not dropped silently because in_ready = 0 there.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-load or mid-drain, immediately set state = LOAD_A and beat counter = 0, and zero A, B, alu_opsel, alu_mode, the result register, out_flags and out_err.
REQ-029 SHALL drive in_ready = 1 and out_valid = out_last = 0 during reset; the partial transaction in progress is discarded.

Configuration
REQ-030 SHALL, with ALU128_STICKY_FLAGS_EN defined, add input sticky_clr (1 bit) and output sticky_o (1 bit); sticky_o is set at each EXEC capture where the o flag = 1, cleared by sticky_clr (clear wins when both occur together), and reset to 0.
REQ-031 SHALL, without ALU128_STICKY_FLAGS_EN, have neither port nor the register; all other behaviour is identical.

Structure
REQ-032 SHALL place the state enum, the ALU_W = 128 constant, the flag bit indices (C = 3, Z = 2, O = 1, S = 0) and the illegal-opsel check function in package alu128_pkg.
REQ-033 SHALL be a single module with no sub-modules; the ALU is external, connected by the bench or the top level.

Verification
REQ-034 SHALL pass this scenario (WORD_W = 32; bench ALU model: result = op1 + op2, flags from the model): mode 0, opsel 000, A words 5, 0, 0, 0x80000000 and B words 9, 0, 0, 0x80000000 -> out words 0xE, 0, 0, 0, out_last on word 3, c = 1, o = 1.
REQ-035 SHALL pass this scenario: A = 0, B = 0, add -> out_flags z = 1, all result words 0.
REQ-036 SHALL pass this scenario: out_ready held low 5 cycles at word 2 -> out_data stays at word 2, and no word is skipped or repeated.
REQ-037 SHALL pass this scenario: mode 1, opsel 110 -> out_err = 1 for the whole drain; the next legal command gives out_err = 0.
REQ-038 SHALL pass this scenario: rst_n pulsed low after A beat 2 -> in_ready = 1 and out_valid = 0; a fresh full transaction completes correctly.
REQ-039 SHALL pass this scenario (macro defined): two overflowing adds then sticky_clr -> sticky_o goes 1, stays 1, then 0 the cycle after the clear.
